// File: rtl/prio_pkg.sv
// prio_pkg: shared state encoding, default width and single-bit test
// for the priority encoder/serialiser family.
package prio_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_W         = 256;

    typedef enum logic {IDLE, SCAN} prio_state_t;

    // True when vec has at most one bit set.
    function automatic logic onehot_le1(input logic [MAX_W-1:0] vec);
        return (vec & (vec - MAX_W'(1))) == '0;
    endfunction

endpackage

// File: rtl/prio_find.sv
// prio_find: combinational priority find over a vector, returning the winning
// index (0 when empty) and an any-set flag.
module prio_find #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int IDX_W     = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan from lowest to highest priority so the last hit wins.
    always_comb begin
        o_idx = '0;
        o_any = |i_vec;
        for (int i = 0; i < WIDTH; i++)
            if (i_vec[MSB_FIRST ? i : WIDTH-1-i])
                o_idx = IDX_W'(MSB_FIRST ? i : WIDTH-1-i);
    end

endmodule

// File: rtl/prio_enc_serializer.sv
// prio_enc_serializer: accepts a request vector and emits the index of each set bit in
// priority order. Define PRIO_SER_ZERO_BEAT_EN to emit one out_zero beat for a zero vector.
module prio_enc_serializer
    import prio_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter int IDX_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
`ifdef PRIO_SER_ZERO_BEAT_EN
    output logic             out_zero,
`endif
    output logic             busy
);

`ifdef PRIO_SER_ZERO_BEAT_EN
    localparam bit ZERO_BEAT = 1'b1;
`else
    localparam bit ZERO_BEAT = 1'b0;
`endif

    prio_state_t      r_state, w_state_n;
    logic [WIDTH-1:0] r_pending, w_pending_n;
    logic             w_any, w_fire, w_load;

    prio_find #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST), .IDX_W(IDX_W)) u_find (
        .i_vec (r_pending),
        .o_idx (out_idx),
        .o_any (w_any)
    );

    // An empty pending set in SCAN only exists for the zero-vector beat.
    assign busy      = r_state == SCAN;
    assign out_valid = busy && (w_any || ZERO_BEAT);
    assign out_last  = out_valid && onehot_le1(MAX_W'(r_pending));
    assign w_fire    = out_valid && out_ready;
    assign in_ready  = !busy || (w_fire && out_last);
    assign w_load    = in_valid && in_ready && (ZERO_BEAT || |in_vec);
`ifdef PRIO_SER_ZERO_BEAT_EN
    assign out_zero  = out_valid && !w_any;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_n;
            r_pending <= w_pending_n;
        end
    end

    // A load on the final beat overrides the return to IDLE (back-to-back).
    always_comb begin
        w_state_n   = r_state;
        w_pending_n = r_pending;
        if (w_fire) begin
            w_pending_n = r_pending & ~(WIDTH'(1) << out_idx);
            w_state_n   = out_last ? IDLE : SCAN;
        end
        if (w_load) begin
            w_pending_n = in_vec;
            w_state_n   = SCAN;
        end
    end

endmodule

// File: doc/prio_enc_serializer.md
Name: prio_enc_serializer

Overview:
- Parametrised, sequential successor to the team's 8-to-3 octal priority encoder.
- Accepts a WIDTH-bit request vector over a valid/ready handshake.
- Emits the index of every set bit, one per output handshake, in priority order, clearing each bit as it is consumed.
- Sits between request-collection logic (interrupt/event vectors) and a single-index consumer.

Parameters:
- WIDTH, 8, width of the request vector; must be at least 2.
- IDX_W, $clog2(WIDTH), width of the output index; derived, do not override.
- MSB_FIRST, 1, 1 = highest set bit has priority (legacy encoder order); 0 = lowest set bit first.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_vec  in  WIDTH  request vector.
- in_valid  in  1  in_vec is valid.
- in_ready  out  1  block can accept in_vec.
- out_idx  out  IDX_W  index of the current highest-priority pending bit.
- out_valid  out  1  out_idx is valid.
- out_ready  in  1  consumer accepts out_idx.
- out_last  out  1  current beat is the final pending bit of this vector.
- busy  out  1  a vector is being serialised (state SCAN).

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset values: pending = 0, state = IDLE, out_valid = 0, out_idx = 0, out_last = 0, busy = 0. in_ready = 1 once rst deasserts.
- Reset asserted mid-operation discards pending immediately. No beat is emitted after reset.
- Internal registers: pending[WIDTH-1:0] and state ∈ {IDLE, SCAN}.
- in_ready = (state == IDLE) || (out_valid && out_ready && out_last).
- out_valid = (state == SCAN).
- out_idx = priority find of pending per MSB_FIRST. It is combinational from registers, with no combinational path from in_*.
- out_last = pending has exactly one bit set.
- IDLE:
  - On in_valid && in_ready with in_vec != 0: pending <= in_vec, go to SCAN.
  - First out_valid appears the cycle after acceptance (latency 1).
- IDLE, zero vector: on in_valid && in_vec == 0, the vector is accepted and dropped and state stays IDLE (see Optional Feature).
- SCAN, beat without last: on out_valid && out_ready && !out_last, clear bit out_idx in pending and stay in SCAN.
- SCAN, final beat: on out_valid && out_ready && out_last:
  - If in_valid with nonzero in_vec is present the same cycle, load pending <= in_vec and stay in SCAN (back-to-back, no bubble).
  - Otherwise pending <= 0 and go to IDLE.
- SCAN stall: with out_ready = 0, out_idx, out_last and pending hold stable. in_ready = 0 and in_vec is ignored.
- Throughput: one index per cycle under continuous out_ready. A vector with k set bits occupies k output cycles.
- All-ones vector, WIDTH = 8, MSB_FIRST = 1: emits 7, 6, 5, 4, 3, 2, 1, 0, with out_last on 0.
- Index arithmetic is unsigned. IDX_W is derived from WIDTH so out_idx never overflows; no wrap-around occurs.

Optional Feature:
- Macro: PRIO_SER_ZERO_BEAT_EN.
- Defined:
  - Adds output port out_zero (1 bit, reset 0).
  - An accepted all-zero vector produces exactly one beat: out_valid = 1, out_idx = 0, out_last = 1, out_zero = 1.
  - This beat replaces the legacy "invalid / don't-care" output with a defined signal.
  - out_zero = 0 on all other beats.
  - State goes to SCAN for that beat; back-to-back loading applies as normal.
- Undefined: port out_zero is absent. An all-zero vector is consumed silently and no beat is emitted.

Decomposition:
- Shared package prio_pkg:
  - state enum prio_state_t {IDLE, SCAN}.
  - function onehot_le1(vec), used for out_last.
  - localparam default WIDTH value.
- One natural sub-module, prio_find:
  - Combinational, parametrised by WIDTH and MSB_FIRST.
  - Takes pending and returns the index plus an any-set flag.
  - Reused by future arbiter blocks.

Test Plan:
- Reset mid-SCAN: load 8'b1010_0000, take one beat (idx 7), assert rst → out_valid = 0, busy = 0 immediately; after release, in_ready = 1 and no stale beats appear.
- Basic order: MSB_FIRST = 1, in_vec = 8'b1001_0010, out_ready = 1 → idx 7, 4, 1 on consecutive cycles, out_last only on 1, then IDLE.
- Back-pressure: in_vec = 8'b0000_0110, out_ready low 3 cycles → idx 2 held stable and in_ready = 0; then release → 2, 1.
- Back-to-back: on the final beat (idx 0 of 8'b0000_0001), present in_vec = 8'b1000_0000 → accepted the same cycle, next cycle idx 7 with no bubble.
- LSB order and width: WIDTH = 16, MSB_FIRST = 0, in_vec = 16'h8101 → idx 0, 8, 15, with out_last on 15.
- Zero vector: in_vec = 0 → without macro, no beat and in_ready stays 1; with PRIO_SER_ZERO_BEAT_EN, one beat idx 0 with out_zero = 1 and out_last = 1.
